disp_seq_param: RTL
===================

DISP_SEQ_PARAM -- requirements
Module: disp_seq_param

Interface
REQ-001 Parameter N_CH, default 8, number of result channels; legal range 2..16.
REQ-002 Parameter W, default 8, width of each channel value in bits; legal range 4..16.
REQ-003 Parameter DWELL_CYC, default 50_000_000, clock cycles each channel is shown in auto mode.
REQ-004 Parameter REFRESH_CYC, default 100_000, clock cycles each digit is driven during scanning.
REQ-005 Parameter LOOP, default 1; 1 = wrap to channel 0 after the last channel, 0 = return to IDLE.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  single-cycle synchronous pulse; snapshot all channels and begin display.
REQ-009 step  input  1  single-cycle synchronous pulse; advance to the next channel.
REQ-010 auto_en  input  1  1 = timed auto-advance; 0 = manual advance on step only.
REQ-011 data_in  input  N_CH*W  packed channel values; channel k occupies bits [k*W+W-1 : k*W].
REQ-012 seg_out  output  8  segment drive, active-low; bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
REQ-013 an_out  output  8  digit anodes, active-low, one-hot-low; bit i selects digit i.
REQ-014 busy  output  1  high while in SHOW.
REQ-015 ch_idx  output  4  index of the channel currently displayed.

Function
REQ-016 The block SHALL implement two states: IDLE and SHOW.
REQ-017 IDLE: seg_out = 8'hFF, an_out = 8'hFF, busy = 0, dwell and scan counters held at 0.
REQ-018 start in IDLE at cycle t: all N_CH channels captured into snapshot registers at t; at t+1 state = SHOW, busy = 1, ch_idx = 0, dwell counter = 0.
REQ-019 Display SHALL use only the snapshot; data_in changes after capture have no effect.
REQ-020 start in SHOW SHALL re-capture the snapshot, set ch_idx = 0 and clear the dwell counter; the state stays SHOW.
REQ-021 Auto mode (auto_en = 1): the dwell counter counts 0..DWELL_CYC-1; on terminal count ch_idx advances by 1 and the counter clears.
REQ-022 Manual mode (auto_en = 0): the dwell counter is held at 0; ch_idx advances only on step.
REQ-023 step in SHOW SHALL advance ch_idx by 1 and clear the dwell counter, regardless of auto_en.
REQ-024 Advance from ch_idx = N_CH-1: if LOOP = 1, ch_idx = 0; if LOOP = 0, state = IDLE and ch_idx = 0.
REQ-025 Simultaneous start and step: start wins; step is ignored.
REQ-026 Simultaneous step and dwell terminal count: advance by exactly 1.
REQ-027 step in IDLE SHALL be ignored.
REQ-028 Scan in SHOW: the scan counter counts 0..REFRESH_CYC-1; on terminal count the digit select increments 0..7 and wraps to 0.
REQ-029 Digit content: digit7 = 'C'; digit6 = ch_idx in hex; digits 5..4 blank; digits 3..0 = snapshot[ch_idx] in hex, LSB nibble on digit0.
REQ-030 Value digits above ceil(W/4)-1 SHALL be blank; for non-multiple-of-4 W, the top nibble is zero-extended.
REQ-031 Blank digit: an_out bit stays 1 (digit off) during that digit's slot; seg_out = 8'hFF.
REQ-032 Font: standard 7-seg hex 0-F (A, b, C, d, E, F); dp is always off (seg_out[7] = 1).
REQ-033 seg_out and an_out SHALL be registered and change on the same edge (no anode/segment skew).

Reset
REQ-034 reset low SHALL immediately force state = IDLE, seg_out = 8'hFF, an_out = 8'hFF, busy = 0, ch_idx = 0, snapshot = 0 and all counters = 0, including mid-SHOW.
REQ-035 After reset is released, the block SHALL stay in IDLE until the next start.

Verification (N_CH=4, W=8, DWELL_CYC=10, REFRESH_CYC=2, LOOP=1 unless stated)
REQ-036 data_in=32'h44_33_22_11, start, auto_en=1 -> busy=1 next cycle; ch_idx sequence 0,1,2,3,0 with 10 cycles each; digits3..0 for ch0 = blank,blank,'1','1'.
REQ-037 auto_en=0, step pulses at irregular spacing -> ch_idx advances exactly once per step, wraps 3->0; it does not advance without step.
REQ-038 LOOP=0, auto_en=1 -> after ch_idx 3 dwells 10 cycles, busy=0, an_out=8'hFF, seg_out=8'hFF.
REQ-039 Change data_in after start; start and step in the same cycle -> snapshot retains the old values until that start; ch_idx=0; step ignored.
REQ-040 Assert reset low mid-SHOW, asynchronous to clk -> outputs reach their reset values before the next edge; no activity until start.
REQ-041 Scan check: an_out walks through the non-blank digits 7,6,1,0 with a 2-cycle slot each; ch1=8'hA5 gives digit0 '5' = 8'b1001_0010 and digit1 'A' = 8'b1000_1000.

Source files
------------

// File: rtl/disp_seq_param.sv
// Purpose: snapshots N_CH packed channel values and shows one channel at a time on an 8-digit, multiplexed 7-seg display.
// Latency: snapshot is taken on the start edge; seg_out/an_out are registered and track the same edge as state/ch_idx/digit select.
// Backpressure: none; start/step are single-cycle pulses, and step is ignored in IDLE or when it coincides with start.
module disp_seq_param #(
   parameter int N_CH        = 8,
   parameter int W           = 8,
   parameter int DWELL_CYC   = 50_000_000,
   parameter int REFRESH_CYC = 100_000,
   parameter int LOOP        = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              step,
   input  logic              auto_en,
   input  logic [N_CH*W-1:0] data_in,
   output logic [7:0]        seg_out,
   output logic [7:0]        an_out,
   output logic              busy,
   output logic [3:0]        ch_idx
);

   localparam int DW  = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
   localparam int RW  = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
   localparam int NIB = (W + 3) / 4;
   localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_CYC - 1);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYC - 1);
   localparam logic [3:0]    CH_LAST      = 4'(N_CH - 1);

   typedef enum logic {IDLE, SHOW} state_t;

   state_t            state_q, state_d;
   logic [N_CH*W-1:0] snap_q, snap_d;
   logic [DW-1:0]     dwell_q, dwell_d;
   logic [RW-1:0]     scan_q, scan_d;
   logic [2:0]        dig_q, dig_d;
   logic [3:0]        ch_q, ch_d;
   logic [7:0]        seg_d, an_d;
   logic [15:0]       sel_val;
   logic [3:0]        nib;

   // Active-low gfedcba pattern for one hex nibble.
   function automatic logic [6:0] font(input logic [3:0] v);
      case (v)
         4'h0: font = 7'h40;  4'h1: font = 7'h79;  4'h2: font = 7'h24;  4'h3: font = 7'h30;
         4'h4: font = 7'h19;  4'h5: font = 7'h12;  4'h6: font = 7'h02;  4'h7: font = 7'h78;
         4'h8: font = 7'h00;  4'h9: font = 7'h10;  4'hA: font = 7'h08;  4'hB: font = 7'h03;
         4'hC: font = 7'h46;  4'hD: font = 7'h21;  4'hE: font = 7'h06;  default: font = 7'h0E;
      endcase
   endfunction

   // State, snapshot, counters and the registered display drive.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         snap_q  <= '0;
         dwell_q <= '0;
         scan_q  <= '0;
         dig_q   <= '0;
         ch_q    <= '0;
         seg_out <= 8'hFF;
         an_out  <= 8'hFF;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         dwell_q <= dwell_d;
         scan_q  <= scan_d;
         dig_q   <= dig_d;
         ch_q    <= ch_d;
         seg_out <= seg_d;
         an_out  <= an_d;
      end
   end

   // Next state: capture on start, advance on step or dwell expiry, run the digit scan while showing.
   always_comb begin
      state_d = state_q;
      snap_d  = start ? data_in : snap_q;
      dwell_d = dwell_q;
      scan_d  = scan_q;
      dig_d   = dig_q;
      ch_d    = ch_q;
      case (state_q)
         IDLE: begin
            dwell_d = '0;
            scan_d  = '0;
            dig_d   = '0;
            ch_d    = '0;
            if (start) state_d = SHOW;
         end
         default: begin
            // The scan keeps running across a restart so the display never stalls.
            if (scan_q == REFRESH_LAST) begin
               scan_d = '0;
               dig_d  = dig_q + 3'd1;
            end else begin
               scan_d = scan_q + RW'(1);
            end
            if (start) begin
               ch_d    = '0;
               dwell_d = '0;
            end else if (step || (auto_en && (dwell_q == DWELL_LAST))) begin
               dwell_d = '0;
               if (ch_q == CH_LAST) begin
                  ch_d = '0;
                  if (LOOP == 0) begin
                     state_d = IDLE;
                     scan_d  = '0;
                     dig_d   = '0;
                  end
               end else begin
                  ch_d = ch_q + 4'd1;
               end
            end else begin
               dwell_d = auto_en ? dwell_q + DW'(1) : '0;
            end
         end
      endcase
   end

   // Decode from next-cycle values so anodes and segments land on the same edge as state and ch_idx.
   always_comb begin
      seg_d   = 8'hFF;
      an_d    = 8'hFF;
      sel_val = '0;
      nib     = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (ch_d == 4'(k)) sel_val = 16'(snap_d[k*W +: W]);
      end
      case (dig_d[1:0])
         2'd0:    nib = sel_val[3:0];
         2'd1:    nib = sel_val[7:4];
         2'd2:    nib = sel_val[11:8];
         default: nib = sel_val[15:12];
      endcase
      if (state_d == SHOW) begin
         if (dig_d == 3'd7) begin
            seg_d = {1'b1, font(4'hC)};
            an_d  = ~(8'd1 << dig_d);
         end else if (dig_d == 3'd6) begin
            seg_d = {1'b1, font(ch_d)};
            an_d  = ~(8'd1 << dig_d);
         end else if ((dig_d < 3'd4) && (int'(dig_d) < NIB)) begin
            seg_d = {1'b1, font(nib)};
            an_d  = ~(8'd1 << dig_d);
         end
      end
   end

   assign busy   = (state_q == SHOW);
   assign ch_idx = ch_q;

endmodule
